// File: rtl/dl_shifter_pipe_pkg.sv
// Shared types and helpers for the pipelined multi-mode barrel shifter.
package dl_shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_op_e;

    localparam int SHIFT_MAX_BITS = 256;

    // Reverses the low 'width' bits; callers zero-extend in and truncate out.
    function automatic logic [SHIFT_MAX_BITS-1:0] bit_reverse(
        input logic [SHIFT_MAX_BITS-1:0] d,
        input int                        width
    );
        logic [SHIFT_MAX_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < SHIFT_MAX_BITS; i++)
            if (i < width) r[i] = d[width-1-i];
        return r;
    endfunction

    // First shift level owned by a stage: ceil(stage * levels / stages).
    function automatic int stage_first_level(input int stage, input int levels, input int stages);
        return (stage * levels + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/dl_shifter_pipe_if.sv
// Request/response handshake bundle for dl_shifter_pipe.
interface dl_shifter_pipe_if #(
    parameter int NUM_BITS = 32
);
    import dl_shift_pkg::*;

    localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS);

    logic                      flush;
    logic                      in_val;
    logic                      in_rdy;
    shift_op_e                 in_op;
    logic [NUM_BITS-1:0]       in_data;
    logic [NUM_SHIFT_BITS-1:0] in_shamt;
    logic                      out_val;
    logic                      out_rdy;
    logic [NUM_BITS-1:0]       out_data;

    modport master (
        output flush, in_val, in_op, in_data, in_shamt, out_rdy,
        input  in_rdy, out_val, out_data
    );

    modport slave (
        input  flush, in_val, in_op, in_data, in_shamt, out_rdy,
        output in_rdy, out_val, out_data
    );

endinterface

// File: rtl/dl_shifter_pipe_stage.sv
// Combinational right-shift levels for one pipeline stage.
// DL_SHIFT_ROTATE_EN builds the wrap-around path used by rotate-right.
module dl_shift_stage #(
    parameter int NUM_BITS    = 32,
    parameter int FIRST_LEVEL = 0,
    parameter int NUM_LEVELS  = 1
) (
    input  logic [NUM_BITS-1:0]   data,
    input  logic [NUM_LEVELS-1:0] shamt,
    input  logic                  fill,
    input  logic                  rotate,
    output logic [NUM_BITS-1:0]   result
);

    logic [NUM_BITS-1:0] d;

`ifndef DL_SHIFT_ROTATE_EN
    logic unused_rotate;
    assign unused_rotate = rotate;
`endif

    always_comb begin
        d = data;
        for (int j = 0; j < NUM_LEVELS; j++) begin
            if (shamt[j]) begin
`ifdef DL_SHIFT_ROTATE_EN
                if (rotate)
                    d = (d >> (1 << (FIRST_LEVEL + j))) | (d << (NUM_BITS - (1 << (FIRST_LEVEL + j))));
                else
`endif
                    d = (d >> (1 << (FIRST_LEVEL + j)))
                      | (fill ? ~({NUM_BITS{1'b1}} >> (1 << (FIRST_LEVEL + j))) : '0);
            end
        end
        result = d;
    end

endmodule

// File: rtl/dl_shifter_pipe.sv
// Pipelined SLL/SRL/SRA/ROR barrel shifter with valid/ready stage handshake.
// Rotate-right is built only when DL_SHIFT_ROTATE_EN is defined (see dl_shift_stage).
module dl_shifter_pipe
    import dl_shift_pkg::*;
#(
    parameter int NUM_BITS   = 32,
    parameter int NUM_STAGES = 2
) (
    input logic              clk,
    input logic              rst_n,
    dl_shifter_pipe_if.slave bus
);

    localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS);

    logic [NUM_STAGES-1:0]                     vld_pipe;
    logic [NUM_STAGES-1:0]                     rdy;
    logic [NUM_STAGES-1:0][NUM_BITS-1:0]       data_q, data_in, data_nxt;
    logic [NUM_STAGES-1:0][1:0]                op_q, op_in;
    logic [NUM_STAGES-1:0][NUM_SHIFT_BITS-1:0] shamt_q, shamt_in;
    logic [NUM_STAGES-1:0]                     fill_q, fill_in, val_in;

    // A stage can take new data if it is empty or everything below it can move.
    always_comb begin
        rdy = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            rdy[k] = bus.out_rdy;
            for (int j = k; j < NUM_STAGES; j++)
                rdy[k] = rdy[k] | ~vld_pipe[j];
        end
    end

    // SLL runs through the right shifter on a bit-reversed operand.
    always_comb begin
        data_in[0]  = (bus.in_op == SHIFT_SLL)
                    ? NUM_BITS'(bit_reverse(SHIFT_MAX_BITS'(bus.in_data), NUM_BITS))
                    : bus.in_data;
        op_in[0]    = bus.in_op;
        shamt_in[0] = bus.in_shamt;
        fill_in[0]  = (bus.in_op == SHIFT_SRA) & bus.in_data[NUM_BITS-1];
        val_in[0]   = bus.in_val;
        for (int k = 1; k < NUM_STAGES; k++) begin
            data_in[k]  = data_q[k-1];
            op_in[k]    = op_q[k-1];
            shamt_in[k] = shamt_q[k-1];
            fill_in[k]  = fill_q[k-1];
            val_in[k]   = vld_pipe[k-1];
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        localparam int FL = stage_first_level(k, NUM_SHIFT_BITS, NUM_STAGES);
        localparam int NL = stage_first_level(k + 1, NUM_SHIFT_BITS, NUM_STAGES) - FL;

        logic [NUM_BITS-1:0] shifted;

        dl_shift_stage #(
            .NUM_BITS    (NUM_BITS),
            .FIRST_LEVEL (FL),
            .NUM_LEVELS  (NL)
        ) u_stage (
            .data   (data_in[k]),
            .shamt  (shamt_in[k][FL +: NL]),
            .fill   (fill_in[k]),
            .rotate (op_in[k] == SHIFT_ROR),
            .result (shifted)
        );

        if (k == NUM_STAGES - 1) begin : g_exit
            assign data_nxt[k] = (op_in[k] == SHIFT_SLL)
                               ? NUM_BITS'(bit_reverse(SHIFT_MAX_BITS'(shifted), NUM_BITS))
                               : shifted;
        end else begin : g_mid
            assign data_nxt[k] = shifted;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            data_q   <= '0;
            op_q     <= '0;
            shamt_q  <= '0;
            fill_q   <= '0;
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (bus.flush)
                    vld_pipe[k] <= 1'b0;
                else if (rdy[k])
                    vld_pipe[k] <= val_in[k];
                if (rdy[k] && val_in[k] && !bus.flush) begin
                    data_q[k]  <= data_nxt[k];
                    op_q[k]    <= op_in[k];
                    shamt_q[k] <= shamt_in[k];
                    fill_q[k]  <= fill_in[k];
                end
            end
        end
    end

    // Last-stage control fields have no consumer past the output register.
    logic unused_tail;
    assign unused_tail = ^{shamt_q[NUM_STAGES-1], fill_q[NUM_STAGES-1], op_q[NUM_STAGES-1]};

    assign bus.in_rdy   = rdy[0];
    assign bus.out_val  = vld_pipe[NUM_STAGES-1];
    assign bus.out_data = data_q[NUM_STAGES-1];

endmodule

// File: tb/tb_dl_shifter_pipe.sv
// Scoreboard bench for dl_shifter_pipe: 2-stage main instance plus 1- and 5-stage sweep instances.
module tb_dl_shifter_pipe;
    import dl_shift_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dl_shifter_pipe_if #(.NUM_BITS(W)) bus2 (), bus1 (), bus5 ();

    dl_shifter_pipe #(.NUM_BITS(W), .NUM_STAGES(2)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus2));
    dl_shifter_pipe #(.NUM_BITS(W), .NUM_STAGES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    dl_shifter_pipe #(.NUM_BITS(W), .NUM_STAGES(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

    int tests = 0;
    int fails = 0;
    logic [W-1:0] q2[$], q1[$], q5[$];

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got timeout/unexpected expected handshake", name);
    endtask

    // Independent reference built from native shift operators.
    function automatic logic [W-1:0] ref_shift(input shift_op_e op, input logic [W-1:0] d, input int s);
        logic signed [W-1:0] sd;
        sd = d;
        case (op)
            SHIFT_SLL: return d << s;
            SHIFT_SRL: return d >> s;
            SHIFT_SRA: return sd >>> s;
            default: begin
`ifdef DL_SHIFT_ROTATE_EN
                return (s == 0) ? d : ((d >> s) | (d << (W - s)));
`else
                return d >> s;
`endif
            end
        endcase
    endfunction

    // Monitors: pop on each output transfer; flush discards whatever is still queued.
    always @(negedge clk) if (rst_n) begin
        if (bus2.out_val && bus2.out_rdy) begin
            if (q2.size() == 0) fail_now("s2 unexpected output");
            else check("s2 result", bus2.out_data, q2.pop_front());
        end
        if (bus2.flush) q2.delete();
    end

    always @(negedge clk) if (rst_n) begin
        if (bus1.out_val && bus1.out_rdy) begin
            if (q1.size() == 0) fail_now("s1 unexpected output");
            else check("s1 result", bus1.out_data, q1.pop_front());
        end
    end

    always @(negedge clk) if (rst_n) begin
        if (bus5.out_val && bus5.out_rdy) begin
            if (q5.size() == 0) fail_now("s5 unexpected output");
            else check("s5 result", bus5.out_data, q5.pop_front());
        end
    end

    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data  = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("stall hold", bus2.out_data, prev_data);
            prev_stall = bus2.out_val && !bus2.out_rdy && !bus2.flush;
            prev_data  = bus2.out_data;
        end
    end

    task automatic issue2(input shift_op_e op, input logic [W-1:0] d, input logic [4:0] s,
                          input logic [W-1:0] exp);
        int n;
        bus2.in_val   = 1'b1;
        bus2.in_op    = op;
        bus2.in_data  = d;
        bus2.in_shamt = s;
        n = 0;
        @(negedge clk);
        while (!bus2.in_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus2.in_rdy) fail_now("s2 accept");
        else q2.push_back(exp);
        @(posedge clk); #1;
        bus2.in_val = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q2.size() != 0 || q1.size() != 0 || q5.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now("drain");
        @(posedge clk); #1;
    endtask

    logic [W-1:0] srl_exp [6] = '{32'hF000_0000, 32'h7800_0000, 32'h3C00_0000,
                                  32'h1E00_0000, 32'h0F00_0000, 32'h0780_0000};

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus2.flush = 1'b0; bus2.in_val = 1'b0; bus2.in_op = SHIFT_SLL; bus2.in_data = '0;
        bus2.in_shamt = '0; bus2.out_rdy = 1'b1;
        bus1.flush = 1'b0; bus1.in_val = 1'b0; bus1.in_op = SHIFT_SLL; bus1.in_data = '0;
        bus1.in_shamt = '0; bus1.out_rdy = 1'b1;
        bus5.flush = 1'b0; bus5.in_val = 1'b0; bus5.in_op = SHIFT_SLL; bus5.in_data = '0;
        bus5.in_shamt = '0; bus5.out_rdy = 1'b1;

        #2;
        check("reset out_val",  W'(bus2.out_val), 32'd0);
        check("reset out_data", bus2.out_data,    32'd0);
        check("reset in_rdy",   W'(bus2.in_rdy),  32'd1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic ops, with a latency check on the first one.
        issue2(SHIFT_SLL, 32'h0000_0001, 5'd5, 32'h0000_0020);
        @(negedge clk); check("latency cycle1 out_val", W'(bus2.out_val), 32'd0);
        @(negedge clk); check("latency cycle2 out_val", W'(bus2.out_val), 32'd1);
        @(posedge clk); #1;
        issue2(SHIFT_SRL, 32'h8000_0000, 5'd4,  32'h0800_0000);
        issue2(SHIFT_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
`ifdef DL_SHIFT_ROTATE_EN
        issue2(SHIFT_ROR, 32'h0000_00F1, 5'd4,  32'h1000_000F);
`else
        issue2(SHIFT_ROR, 32'h0000_00F1, 5'd4,  32'h0000_000F);
`endif
        drain();

        // Boundaries: zero shift for every op, SRA of a positive word by 31.
        issue2(SHIFT_SLL, 32'h8765_4321, 5'd0,  32'h8765_4321);
        issue2(SHIFT_SRL, 32'h8765_4321, 5'd0,  32'h8765_4321);
        issue2(SHIFT_SRA, 32'h8765_4321, 5'd0,  32'h8765_4321);
        issue2(SHIFT_ROR, 32'h8765_4321, 5'd0,  32'h8765_4321);
        issue2(SHIFT_SRA, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000);
        issue2(SHIFT_SLL, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000);
        drain();

        // Streaming with a 4-cycle consumer stall mid-stream.
        fork
            begin
                for (int i = 0; i < 6; i++)
                    issue2(SHIFT_SRL, 32'hF000_0000, 5'(i), srl_exp[i]);
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus2.out_rdy = 1'b0;
                repeat (3) @(negedge clk);
                @(negedge clk);
                check("stall in_rdy",  W'(bus2.in_rdy),  32'd0);
                check("stall out_val", W'(bus2.out_val), 32'd1);
                @(posedge clk); #1 bus2.out_rdy = 1'b1;
            end
        join
        drain();

        // Random sweep of the 1- and 5-stage instances against the model.
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] d;
            shift_op_e    op;
            logic [4:0]   s;
            logic [W-1:0] e;
            d  = $urandom;
            op = shift_op_e'($urandom_range(0, 3));
            s  = (i < 4) ? 5'd0 : (i < 8) ? 5'd31 : 5'($urandom_range(0, 31));
            bus1.in_val = 1'b1; bus1.in_op = op; bus1.in_data = d; bus1.in_shamt = s;
            bus5.in_val = 1'b1; bus5.in_op = op; bus5.in_data = d; bus5.in_shamt = s;
            e = ref_shift(op, d, int'(s));
            @(negedge clk);
            if (bus1.in_rdy) q1.push_back(e); else fail_now("s1 accept");
            if (bus5.in_rdy) q5.push_back(e); else fail_now("s5 accept");
            @(posedge clk); #1;
        end
        bus1.in_val = 1'b0;
        bus5.in_val = 1'b0;
        drain();

        // Flush with a request presented in the flush cycle.
        issue2(SHIFT_SRL, 32'h0000_1000, 5'd4, 32'h0000_0100);
        issue2(SHIFT_SRL, 32'h0000_2000, 5'd4, 32'h0000_0200);
        bus2.flush = 1'b1; bus2.in_val = 1'b1; bus2.in_op = SHIFT_SRL;
        bus2.in_data = 32'hDEAD_BEEF; bus2.in_shamt = 5'd0;
        @(negedge clk);
        check("flush in_rdy", W'(bus2.in_rdy), 32'd1);
        @(posedge clk); #1;
        bus2.flush = 1'b0; bus2.in_val = 1'b0;
        @(negedge clk); check("post-flush out_val c1", W'(bus2.out_val), 32'd0);
        @(negedge clk); check("post-flush out_val c2", W'(bus2.out_val), 32'd0);
        @(posedge clk); #1;
        issue2(SHIFT_SLL, 32'h0000_0003, 5'd1, 32'h0000_0006);
        drain();

        // Asynchronous reset with a full, stalled pipeline.
        bus2.out_rdy = 1'b0;
        issue2(SHIFT_SRL, 32'h0000_00AA, 5'd1, 32'h0000_0055);
        issue2(SHIFT_SRL, 32'h0000_00BB, 5'd0, 32'h0000_00BB);
        #1;
        check("full out_val",  W'(bus2.out_val), 32'd1);
        check("full in_rdy",   W'(bus2.in_rdy),  32'd0);
        check("full out_data", bus2.out_data,    32'h0000_0055);
        #1 rst_n = 1'b0;
        #1;
        check("async rst out_val",  W'(bus2.out_val), 32'd0);
        check("async rst out_data", bus2.out_data,    32'd0);
        q2.delete();
        #3 rst_n = 1'b1;
        bus2.out_rdy = 1'b1;
        @(posedge clk); #1;
        check("post-rst in_rdy",  W'(bus2.in_rdy),  32'd1);
        check("post-rst out_val", W'(bus2.out_val), 32'd0);
        issue2(SHIFT_SRA, 32'hF000_0000, 5'd8, 32'hFFF0_0000);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
